// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives the combinational imem, and loads IF/ID with stall/redirect/halt handling.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          PROG_WORDS  = 50,
    parameter int          BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_flushes
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state, state_nx;
    logic [31:0] boot_cnt, boot_cnt_nx;
    logic [31:0] pc_nx, instr_nx, pc4_nx;
    logic        valid_nx;
    logic        out_of_image;
    logic [31:0] pc_plus4;

    assign imem_addr    = pc;
    assign halted       = (state == HALT);
    assign pc_plus4     = pc + 32'd4;
    assign out_of_image = ({2'b00, pc[31:2]} >= 32'(PROG_WORDS));

    always_comb begin
        state_nx    = state;
        boot_cnt_nx = boot_cnt;
        pc_nx       = pc;
        instr_nx    = ifid_instr;
        pc4_nx      = ifid_pc4;
        valid_nx    = ifid_valid;
        case (state)
            BOOT: begin
                instr_nx = 32'h0;
                pc4_nx   = 32'h0;
                valid_nx = 1'b0;
                if (boot_cnt >= 32'(BOOT_CYCLES - 1)) state_nx = RUN;
                else boot_cnt_nx = boot_cnt + 32'd1;
            end
            RUN: begin
                if (out_of_image) begin
                    state_nx = HALT;
                    instr_nx = 32'h0;
                    pc4_nx   = 32'h0;
                    valid_nx = 1'b0;
                end else if (stall) begin
                    // hold everything; the hazard unit re-presents any redirect later
                end else if (branch_taken || jump) begin
                    pc_nx    = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
                    instr_nx = 32'h0;
                    pc4_nx   = 32'h0;
                    valid_nx = 1'b0;
                end else begin
                    pc_nx    = pc_plus4;
                    instr_nx = imem_instr;
                    pc4_nx   = pc_plus4;
                    valid_nx = 1'b1;
                end
            end
            default: begin
                instr_nx = 32'h0;
                pc4_nx   = 32'h0;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            boot_cnt   <= 32'h0;
            pc         <= RESET_PC;
            ifid_instr <= 32'h0;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            boot_cnt   <= boot_cnt_nx;
            pc         <= pc_nx;
            ifid_instr <= instr_nx;
            ifid_pc4   <= pc4_nx;
            ifid_valid <= valid_nx;
        end
    end

`ifdef FETCH_PERF_EN
    logic run_ok, fetch_ev, stall_ev, flush_ev;

    assign run_ok   = (state == RUN) && !out_of_image;
    assign stall_ev = (state == RUN) && stall;
    assign fetch_ev = run_ok && !stall && !branch_taken && !jump;
    assign flush_ev = run_ok && !stall && (branch_taken || jump);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 32'h0;
            perf_stalls  <= 32'h0;
            perf_flushes <= 32'h0;
        end else begin
            if (fetch_ev && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
            if (stall_ev && perf_stalls  != 32'hFFFF_FFFF) perf_stalls  <= perf_stalls + 32'd1;
            if (flush_ev && perf_flushes != 32'hFFFF_FFFF) perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: behavioural model checked every negedge plus literal pins.
module tb_fetch_sequencer;
    localparam int PW = 50;
    localparam int BC = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] imem_addr, imem_instr, pc, ifid_instr, ifid_pc4;
    logic        ifid_valid, halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalls, perf_flushes;
`endif

    fetch_sequencer #(.RESET_PC(32'h0), .PROG_WORDS(PW), .BOOT_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_addr(imem_addr), .imem_instr(imem_instr), .pc(pc),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .halted(halted)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    // instruction memory image: word i holds i+1
    assign imem_instr = {2'b00, imem_addr[31:2]} + 32'd1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: fetch rules stated directly in terms of addresses and word values
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halt;
    int          m_boot_left;
    int          m_fetched, m_stalls, m_flushes;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
            m_halt <= 1'b0; m_boot_left <= BC;
            m_fetched <= 0; m_stalls <= 0; m_flushes <= 0;
        end else if (m_halt || m_boot_left > 0) begin
            m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
            if (!m_halt) m_boot_left <= m_boot_left - 1;
        end else begin
            if (stall) m_stalls <= m_stalls + 1;
            if ((m_pc >> 2) >= PW) begin
                m_halt <= 1'b1;
                m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
            end else if (stall) begin
            end else if (branch_taken || jump) begin
                m_pc <= (branch_taken ? branch_target : jump_target) / 4 * 4;
                m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
                m_flushes <= m_flushes + 1;
            end else begin
                m_instr <= m_pc / 4 + 1;
                m_pc4 <= m_pc + 4;
                m_valid <= 1'b1;
                m_pc <= m_pc + 4;
                m_fetched <= m_fetched + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc4", ifid_pc4, m_pc4);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        chk("halted", {31'b0, halted}, {31'b0, m_halt});
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'(m_fetched));
        chk("perf_stalls", perf_stalls, 32'(m_stalls));
        chk("perf_flushes", perf_flushes, 32'(m_flushes));
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
        step(2);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        reset = 1'b0;

        // boot then ramp
        step(1);
        chk("boot_valid", {31'b0, ifid_valid}, 32'h0);
        step(1);
        chk("ramp_i1", ifid_instr, 32'd1);
        chk("ramp_p1", ifid_pc4, 32'd4);
        step(2);
        chk("ramp_i3", ifid_instr, 32'd3);
        chk("ramp_p3", ifid_pc4, 32'd12);
        step(1);
        chk("pc_0x10", pc, 32'h10);

        // two-cycle stall at 0x10
        stall = 1'b1;
        step(2);
        chk("stall_pc", pc, 32'h10);
        chk("stall_instr", ifid_instr, 32'd4);
        stall = 1'b0;
        step(1);
        chk("resume_instr", ifid_instr, 32'd5);

        // branch at 0x24 to 0x48
        step(4);
        chk("pc_0x24", pc, 32'h24);
        branch_taken = 1'b1; branch_target = 32'h48;
        step(1);
        branch_taken = 1'b0;
        chk("br_pc", pc, 32'h48);
        chk("br_valid", {31'b0, ifid_valid}, 32'h0);
        chk("br_instr", ifid_instr, 32'h0);
        step(1);
        chk("br_word18", ifid_instr, 32'd19);
`ifdef FETCH_PERF_EN
        chk("perf_stalls_lit", perf_stalls, 32'd2);
        chk("perf_flushes_lit", perf_flushes, 32'd1);
        chk("perf_fetched_lit", perf_fetched, 32'd10);
`endif

        // stall with jump pending, then jump alone (low target bits dropped)
        stall = 1'b1; jump = 1'b1; jump_target = 32'h3A;
        step(1);
        chk("sj_pc", pc, 32'h4C);
        chk("sj_valid", {31'b0, ifid_valid}, 32'h1);
        stall = 1'b0;
        step(1);
        jump = 1'b0;
        chk("j_pc", pc, 32'h38);
        chk("j_valid", {31'b0, ifid_valid}, 32'h0);
        step(1);
        chk("j_word14", ifid_instr, 32'd15);

        // run off the end of the image
        step(35);
        chk("end_pc", pc, 32'hC8);
        chk("end_instr", ifid_instr, 32'd50);
        step(1);
        chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("halt_valid", {31'b0, ifid_valid}, 32'h0);
        step(3);
        chk("halt_pc", pc, 32'hC8);
        reset = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_halted", {31'b0, halted}, 32'h0);
        step(1);
        reset = 1'b0;

        // redirect to out-of-image target: loads pc, halts without fetching
        step(2);
        branch_taken = 1'b1; branch_target = 32'h103;
        step(1);
        branch_taken = 1'b0;
        chk("oob_pc", pc, 32'h100);
        step(1);
        chk("oob_halt", {31'b0, halted}, 32'h1);
        chk("oob_valid", {31'b0, ifid_valid}, 32'h0);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
